// File: rtl/timer_entry.sv
`default_nettype none
// ============================================================================
//  Module   : timer_entry
//  Brief    : Front-panel input stage: button debounce and two-digit keypad
//             heat-time entry for the microwave controller.
//  Revision : 1.0  initial release
// ============================================================================

module timer_entry_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int                CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // The run counter only advances while raw disagrees with the accepted
    // level; any agreeing sample restarts the run, so short glitches vanish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (raw != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= raw;
                    r_cnt   <= '0;
                    r_pulse <= raw;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule

module timer_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEFAULT_TIME    = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       entry_enable,
    input  logic       start_raw,
    input  logic       cancel_raw,
    output logic [6:0] timer,
    output logic [1:0] digit_count,
    output logic       start_button,
    output logic       cancel_button,
    output logic       entry_error
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [6:0] C_DEFAULT  = 7'(DEFAULT_TIME);
    localparam logic [3:0] C_MAX_DIG  = 4'd9;
    localparam logic [3:0] C_CLEAR    = 4'd10;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [6:0] r_val;
    logic [6:0] w_val_next;
    logic       r_key_prev;
    logic       w_key_rise;
    logic       w_err_next;
    logic [6:0] w_timer_next;
    logic [6:0] r_timer;
    logic       r_error;

    timer_entry_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_db (
        .clk   (clk),
        .reset (reset),
        .raw   (start_raw),
        .pulse (start_button)
    );

    timer_entry_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cancel_db (
        .clk   (clk),
        .reset (reset),
        .raw   (cancel_raw),
        .pulse (cancel_button)
    );

    assign w_key_rise = key_valid & ~r_key_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_val      <= '0;
            r_key_prev <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_val      <= w_val_next;
            r_key_prev <= key_valid;
        end
    end

    // Cancel outranks a coincident keypress; the key is simply dropped.
    always_comb begin
        w_state_next = r_state;
        w_val_next   = r_val;
        w_err_next   = 1'b0;
        if (cancel_button) begin
            w_state_next = S_EMPTY;
            w_val_next   = '0;
        end else if (w_key_rise && entry_enable) begin
            if (key_code <= C_MAX_DIG) begin
                case (r_state)
                    S_EMPTY: begin
                        w_val_next   = 7'(key_code);
                        w_state_next = S_ONE;
                    end
                    S_ONE: begin
                        w_val_next   = r_val * 7'd10 + 7'(key_code);
                        w_state_next = S_FULL;
                    end
                    S_FULL: begin
                        w_err_next = 1'b1;
                    end
                    default: begin
                        w_state_next = S_EMPTY;
                        w_val_next   = '0;
                    end
                endcase
            end else if (key_code == C_CLEAR) begin
                w_state_next = S_EMPTY;
                w_val_next   = '0;
            end else begin
                w_err_next = 1'b1;
            end
        end
    end

    always_comb begin
        w_timer_next = (w_state_next == S_EMPTY) ? C_DEFAULT : w_val_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= C_DEFAULT;
            r_error <= 1'b0;
        end else begin
            r_timer <= w_timer_next;
            r_error <= w_err_next;
        end
    end

    assign timer       = r_timer;
    assign entry_error = r_error;
    assign digit_count = r_state;

endmodule

`default_nettype wire
